fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
- Round-robin write scheduler and drain controller for the byte-in / serial-out FIFO.
- Arbitrates NUM_REQ byte producers onto the single fifo_in/fifo_in_valid port, at most one byte per cycle.
- Tracks FIFO occupancy with a conservative credit counter so the FIFO never overflows.
- Issues rd_en to start serialization, and counts serial bits to detect byte completion.

Parameters:
- NUM_REQ, 4, number of byte producers.
- ID_W, 2, width of grant_id; must equal clog2(NUM_REQ).
- DATA_W, 8, byte width; equals serialized bits per byte.
- DEPTH, 31, maximum outstanding bytes (written but not fully serialized).
- CNT_W, 6, occupancy counter width; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  NUM_REQ  per-producer byte valid.
- req_data  in  NUM_REQ*DATA_W  producer i's byte at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; transfer happens when req_valid[i] && req_ready[i].
- drain_en  in  1  permits starting serialization of queued bytes.
- fifo_out_valid  in  1  serial-valid from the FIFO, sampled on posedge.
- fifo_in  out  DATA_W  byte to the FIFO.
- fifo_in_valid  out  1  write strobe to the FIFO.
- rd_en  out  1  start-serialization request to the FIFO.
- grant_id  out  ID_W  index of the producer accepted this cycle; 0 when none.
- level  out  CNT_W  outstanding byte count.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky underflow flag.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0, bit_cnt=0, level=0, FSM=IDLE. Reset asserted mid-transfer aborts everything immediately, and no pending grant survives.
- Bit counter:
  - While fifo_out_valid=1, bit_cnt increments each cycle and wraps DATA_W-1→0.
  - byte_done = fifo_out_valid && bit_cnt==DATA_W-1.
  - When fifo_out_valid=0, bit_cnt is forced to 0.
- Write blocking: block_wr = byte_done (combinational). This is the FIFO's reload cycle; a write then could be lost through its bypass path, so no writes are taken on it.
- Arbitration (combinational grant, registered pointer):
  - can_wr = (level < DEPTH) && !block_wr.
  - If can_wr, grant goes to the first asserted req_valid searching from rr_ptr upward, modulo NUM_REQ.
  - Only the granted bit of req_ready is 1; fifo_in = granted req_data; fifo_in_valid = 1.
  - After an accept, rr_ptr <= granted index + 1 (mod NUM_REQ). With no accept, rr_ptr holds.
  - fifo_in = 0 when there is no accept.
- Occupancy:
  - level += accept, level -= byte_done. Both in the same cycle leaves level unchanged; this case cannot occur because writes are blocked on byte_done.
  - level never exceeds DEPTH.
  - byte_done with level==0 sets err. level stays 0; err clears only on reset.
- FSM:
  - IDLE: rd_en = drain_en && (level!=0 || fifo_in_valid). If rd_en=1, go to START.
  - START: rd_en=0. If fifo_out_valid=1, go to RUN; otherwise stay. If 4 cycles pass without fifo_out_valid, set err and return to IDLE.
  - RUN: on byte_done, go to IDLE if level==1, else stay in RUN. This mirrors the FIFO returning idle once empty and chaining the next byte otherwise.
  - drain_en low does not interrupt RUN; it only stops new starts from IDLE.
- busy = FSM != IDLE.
- Latency:
  - Byte accepted in cycle t while IDLE with drain_en=1 → rd_en in cycle t, the same cycle (the FIFO bypass is legal here).
  - fifo_out_valid is high for cycles t+1..t+DATA_W.
  - level returns to 0 after the byte_done at cycle t+DATA_W.

Test Plan:
- Single byte: req_valid=0001, req_data[7:0]=8'hA5, drain_en=1 → req_ready=0001, fifo_in=A5 and rd_en in the same cycle, level 1 → 0 after 8 serial-valid cycles, busy falls, err=0.
- Fairness: all four requesters held valid with drain_en=0 for 8 cycles → grant_id sequence 0,1,2,3,0,1,2,3; level=8.
- Full: drain_en=0, requester 2 always valid → exactly 31 accepts, then req_ready=0 with level=31. Raise drain_en → one accept resumes only after the first byte_done.
- Reload blocking: 3 queued bytes, requester 1 always valid during drain → req_ready=0 and fifo_in_valid=0 on every byte_done cycle, and no accept lost. The FSM stays in RUN until level reaches 0 after 24+ serial cycles.
- Reset mid-RUN: assert rst_n=0 at bit 4 of a byte → all outputs 0 asynchronously; after release, a new byte is served normally with level starting from 0.
- Error: hold fifo_out_valid=1 externally for 8 cycles with level=0 → err=1 and stays 1 until reset.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
`timescale 1ns/1ps
// fifo_rr_scheduler
// Round-robin write scheduler and drain controller for a byte-in / serial-out
// FIFO. Several byte producers share one FIFO write port, outstanding bytes are
// tracked with a conservative credit counter, and serialization is started
// with rd_en while serial bits are counted to find byte boundaries.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_req_valid        per-producer byte valid
//   i_req_data         producer i byte at [i*DATA_W +: DATA_W]
//   o_req_ready        one-hot accept (combinational grant)
//   i_drain_en         permits starting serialization from IDLE
//   i_fifo_out_valid   serial-valid from the FIFO
//   o_fifo_in          granted byte, 0 when nothing is accepted
//   o_fifo_in_valid    FIFO write strobe
//   o_rd_en            start-serialization request
//   o_grant_id         accepted producer index, 0 when none
//   o_level            outstanding byte count
//   o_busy             controller not idle
//   o_err              sticky underflow / start-timeout flag
module fifo_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 31,
    parameter int unsigned CNT_W   = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_drain_en,
    input  logic                      i_fifo_out_valid,
    output logic [DATA_W-1:0]         o_fifo_in,
    output logic                      o_fifo_in_valid,
    output logic                      o_rd_en,
    output logic [ID_W-1:0]           o_grant_id,
    output logic [CNT_W-1:0]          o_level,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int unsigned BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned START_TMO = 4;
    localparam int unsigned TMO_W     = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_level;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_busy;
    logic               r_err;

    logic               w_byte_done;
    logic               w_can_wr;
    logic               w_accept;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [DATA_W-1:0]  w_gnt_data;
    logic               w_rd_en;
    logic               w_tmo;

    // (base + ofs) mod NUM_REQ; both operands are already below NUM_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned    ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Last serial bit of a byte; the FIFO reloads on this cycle
    assign w_byte_done = i_fifo_out_valid && (r_bit_cnt == BIT_W'(DATA_W - 1));

    // Writes are refused while reset is asserted so no grant leaks out of reset
    assign w_can_wr = i_rst_n && (r_level < CNT_W'(DEPTH)) && !w_byte_done;

    // Round-robin search starting at rr_ptr
    always_comb begin
        w_accept  = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_can_wr && !w_accept && i_req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_accept  = 1'b1;
                w_gnt_idx = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // Granted byte and one-hot ready
    always_comb begin
        w_gnt_data  = '0;
        o_req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_accept && (w_gnt_idx == ID_W'(i))) begin
                w_gnt_data     = i_req_data[i*DATA_W +: DATA_W];
                o_req_ready[i] = 1'b1;
            end
        end
    end

    assign o_fifo_in       = w_gnt_data;
    assign o_fifo_in_valid = w_accept;
    assign o_grant_id      = w_gnt_idx;
    assign o_rd_en         = w_rd_en;
    assign o_level         = r_level;
    assign o_busy          = r_busy;
    assign o_err           = r_err;

    // Serial bit counter, cleared whenever the serial stream pauses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else if (!i_fifo_out_valid || w_byte_done) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
    end

    // Round-robin pointer, occupancy credits and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
            r_level  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= wrap_idx(w_gnt_idx, 1);
            end
            if (w_accept && !w_byte_done) begin
                r_level <= r_level + CNT_W'(1);
            end else if (w_byte_done && !w_accept && (r_level != '0)) begin
                r_level <= r_level - CNT_W'(1);
            end
            if ((w_byte_done && (r_level == '0)) || w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    // State register, busy flag and START timeout counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if ((r_state == S_START) && !i_fifo_out_valid) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    // Next-state and rd_en
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_drain_en && ((r_level != '0) || w_accept)) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (i_fifo_out_valid) begin
                    w_state_nxt = S_RUN;
                end else if (r_tmo_cnt == TMO_W'(START_TMO - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // FIFO goes idle after its last byte, otherwise chains the next
                if (w_byte_done && (r_level == CNT_W'(1))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
`timescale 1ns/1ps
// Testbench for fifo_rr_scheduler: an environment model plays the FIFO
// serializer, a reference model predicts each cycle's response, and a
// negedge monitor pops the predictions and compares them with the DUT.
module tb_fifo_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        drain_en;
    logic        fov;
    logic [7:0]  fifo_in;
    logic        fifo_in_valid;
    logic        rd_en;
    logic [1:0]  grant_id;
    logic [5:0]  level;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    fifo_rr_scheduler dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .i_drain_en       (drain_en),
        .i_fifo_out_valid (fov),
        .o_fifo_in        (fifo_in),
        .o_fifo_in_valid  (fifo_in_valid),
        .o_rd_en          (rd_en),
        .o_grant_id       (grant_id),
        .o_level          (level),
        .o_busy           (busy),
        .o_err            (err)
    );

    typedef struct packed {
        logic [3:0] ready;
        logic       fiv;
        logic [7:0] fin;
        logic [1:0] gid;
        logic       rd;
        logic [5:0] level;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model: outstanding count, next round-robin start, serial bit
    // position, sticky error; environment: serializer on/off, start timer.
    int m_level, m_ptr, m_bit, m_timer, mode;
    bit m_err, ser_on, force_fov;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    function automatic void model_reset();
        m_level = 0; m_ptr = 0; m_bit = 0; m_timer = 0;
        m_err = 0; ser_on = 0; force_fov = 0;
    endfunction

    // One clock of stimulus: predict the response, queue it, advance the model
    task automatic cycle(input logic [3:0] v, input logic d, input logic [31:0] data);
        exp_t e;
        int   gid;
        bit   bd, acc, busy_e, rd_e;
        req_valid = v;
        req_data  = data;
        drain_en  = d;
        fov       = (mode == 2) ? force_fov : ((mode == 0) ? ser_on : 1'b0);
        bd        = fov && (m_bit == DW - 1);
        gid       = -1;
        if (m_level < DEPTH && !bd) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (gid < 0 && v[idx]) gid = idx;
            end
        end
        acc    = (gid >= 0);
        busy_e = (mode == 1) ? (m_timer != 0) : ser_on;
        rd_e   = !busy_e && d && (m_level != 0 || acc);
        e = '0;
        if (acc) begin
            e.ready = 4'(1 << gid);
            e.fin   = data[gid*8 +: 8];
            e.gid   = 2'(gid);
        end
        e.fiv   = acc;
        e.rd    = rd_e;
        e.level = 6'(m_level);
        e.busy  = busy_e;
        e.err   = m_err;
        sb_q.push_back(e);
        if (acc) begin
            m_level++;
            m_ptr = (gid + 1) % NREQ;
        end else if (bd) begin
            if (m_level > 0) m_level--;
            else m_err = 1;
        end
        m_bit = fov ? (m_bit + 1) % DW : 0;
        if (mode == 0) begin
            // the FIFO chains bytes until it runs empty
            if (ser_on) begin
                if (bd && m_level == 0) ser_on = 0;
            end else if (rd_e) begin
                ser_on = 1;
            end
        end else if (mode == 1) begin
            // silent FIFO: controller gives up after 4 cycles
            if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) m_err = 1;
            end else if (rd_e) begin
                m_timer = 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 400 && (m_level != 0 || ser_on); i++)
            cycle(4'b0000, 1'b1, $urandom());
        if (m_level != 0 || ser_on) chk("drain_timeout", 32'(level), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_fin"},   32'(fifo_in), 32'd0);
        chk({tag, "_fiv"},   32'(fifo_in_valid), 32'd0);
        chk({tag, "_rd"},    32'(rd_en), 32'd0);
        chk({tag, "_gid"},   32'(grant_id), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
    endtask

    // Asynchronous reset with requests held, checked before any clock edge
    task automatic do_reset(string tag, input logic [3:0] v);
        req_valid = v;
        drain_en  = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        req_valid = '0;
        drain_en  = 1'b0;
        fov       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mode = 0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one prediction per stimulated cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                chk("fifo_in_valid", 32'(fifo_in_valid), 32'(e.fiv));
                chk("fifo_in", 32'(fifo_in), 32'(e.fin));
                chk("grant_id", 32'(grant_id), 32'(e.gid));
                chk("rd_en", 32'(rd_en), 32'(e.rd));
                chk("level", 32'(level), 32'(e.level));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; drain_en = 1'b0; fov = 1'b0;
        mode = 0;
        model_reset();
        #3 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte straight through
        cycle(4'b0001, 1'b1, 32'h0000_00A5);
        drain_all();

        // fairness with all producers requesting
        repeat (8) cycle(4'b1111, 1'b0, $urandom());
        chk("fair_level", 32'(level), 32'd8);
        drain_all();

        // fill to DEPTH, then drain while producer 2 keeps pushing
        repeat (35) cycle(4'b0100, 1'b0, $urandom());
        chk("full_level", 32'(level), 32'd31);
        repeat (40) cycle(4'b0100, 1'b1, $urandom());
        drain_all();

        // writes blocked on reload cycles while chaining
        repeat (3) cycle(4'b0001, 1'b0, $urandom());
        repeat (30) cycle(4'b0010, 1'b1, $urandom());
        drain_all();

        // random traffic
        repeat (600) cycle(4'($urandom()), 1'(($urandom() % 4) != 0), $urandom());
        drain_all();

        // reset in the middle of a byte
        cycle(4'b0001, 1'b1, $urandom());
        for (int i = 0; i < 20 && !(ser_on && m_bit == 4); i++)
            cycle(4'b0000, 1'b1, $urandom());
        fov = 1'b1;
        do_reset("mid_run", 4'b1111);
        cycle(4'b0010, 1'b1, 32'h0000_3C00);
        drain_all();

        // FIFO never answers rd_en
        mode = 1;
        cycle(4'b0001, 1'b1, $urandom());
        repeat (7) cycle(4'b0000, 1'b0, $urandom());
        do_reset("after_tmo", 4'b0000);

        // serial-valid forced with nothing outstanding
        mode = 2;
        force_fov = 1;
        repeat (8) cycle(4'b0000, 1'b0, $urandom());
        force_fov = 0;
        repeat (5) cycle(4'b0000, 1'b0, $urandom());
        chk("err_sticky", 32'(err), 32'd1);
        do_reset("after_err", 4'b0000);

        @(negedge clk);
        #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
